instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Parametrised, decoupled instruction fetch stage.
- Generates sequential PCs (+4) from a programmable reset vector and issues pipelined requests to instruction memory.
- Buffers in-order responses in a prefetch FIFO and presents {pc, instr} to decode with valid/ready back-pressure.
- Supports redirect (branch/jump/trap) with FIFO flush and discard of in-flight responses.

Parameters:
- XLEN, 32: address/PC width.
- ILEN, 32: instruction width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FIFO_DEPTH, 4: prefetch entries. Power of two, minimum 2.

Ports:
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. In order, never back-pressured.
- imem_rsp_data  in  ILEN  fetched instruction.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  XLEN  redirect target. Bits [1:0] are ignored and treated as 0.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode consumes head.
- dec_pc  out  XLEN  PC of head instruction.
- dec_instr  out  ILEN  head instruction.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - fetch_pc = RESET_PC and rsp_pc = RESET_PC.
  - outstanding = 0, drop_cnt = 0, FIFO empty.
  - imem_req_valid = 0, dec_valid = 0.
  - dec_pc and dec_instr are 0 while empty.
- Integration requirement: imem must be reset by the same rst. Responses arriving while rst = 1 are ignored.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). Every accepted request is therefore guaranteed a FIFO slot.
- imem_req_addr = fetch_pc, always driven.
- Request fire (valid && ready): fetch_pc <= fetch_pc + 4, with XLEN wrap-around. 32'hFFFF_FFFC wraps to 0.
- outstanding counter:
  - Width clog2(FIFO_DEPTH+1).
  - +1 on request fire, -1 on response, net 0 when both occur in one cycle.
- Response with drop_cnt = 0:
  - Push {rsp_pc, imem_rsp_data} into the FIFO.
  - rsp_pc <= rsp_pc + 4.
- Response with drop_cnt > 0:
  - Discard the response; drop_cnt decrements.
  - rsp_pc is unchanged.
- FIFO:
  - A write becomes visible on dec_* the next cycle.
  - Minimum latency from request fire to dec_valid = memory latency + 1 cycle.
  - Pop on dec_valid && dec_ready. Push and pop in the same cycle are both allowed when full.
- Stall: when dec_ready = 0 the head holds stable. Requests continue until credits are exhausted, then imem_req_valid drops.
- Redirect (redirect_valid = 1):
  - No request is issued that cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00} and rsp_pc <= the same value.
  - FIFO flushed; any simultaneous pop or push is cancelled.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0) - (drop_cnt > 0 && imem_rsp_valid ? 0 : 0), i.e. all pending unreturned responses are marked for discard.
  - A response arriving in the redirect cycle is itself discarded.
  - dec_valid = 0 in the following cycle.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed each time from current outstanding.
- Invariant: drop_cnt <= outstanding <= FIFO_DEPTH. A response with outstanding = 0 is a protocol error (assertion only, no recovery).
- No internal state machine beyond the counters. States implied:
  - RUN: credits available.
  - HOLD: credit-limited.
  - DRAIN: drop_cnt > 0.
  - Transitions follow the counters above.

Decomposition:
- Shared package core_pkg:
  - XLEN, ILEN constants.
  - t_xlen, t_instr typedefs.
  - RESET_PC default.
  - PC_INCR = 4.
  - Struct t_fetch_entry {t_xlen pc; t_instr instr}.
- One sub-module, sync_flush_fifo:
  - Parametrised width and depth.
  - Synchronous active-high rst, flush, push/pop, full/empty, count outputs.
  - Instantiated with t_fetch_entry.

Test Plan:
- Reset then 1-cycle memory latency, dec_ready = 1 → dec_pc sequence 0x0, 0x4, 0x8 on consecutive cycles after a 2-cycle startup; instr data matches memory.
- dec_ready = 0 for 10 cycles, FIFO_DEPTH = 4 → exactly 4 requests issued, imem_req_valid = 0 afterwards, head pc 0x0 stable. Release → 0x0, 0x4, 0x8, 0xC drained, fetch resumes at 0x10.
- 3-cycle memory latency, 3 requests in flight (0x0, 0x4, 0x8), redirect_pc = 0x100 → three responses discarded, next dec_pc = 0x100 with 0x100's instruction, no stale entry ever valid.
- Redirect coincident with a response and with dec pop → response dropped, FIFO empty next cycle, drop_cnt = outstanding - 1.
- redirect_pc = 0x203 → imem_req_addr = 0x200. Redirect to 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream with 2 outstanding and FIFO half full → next cycle imem_req_addr = RESET_PC, dec_valid = 0, counters 0; first post-reset dec_pc = RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the fetch path.
// Provides the machine widths, PC/instruction typedefs, the default reset
// vector, the sequential PC increment, the prefetch entry layout and a
// word-alignment helper.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] t_xlen;
  typedef logic [ILEN-1:0] t_instr;

  localparam t_xlen RESET_PC = 32'h0000_0000;
  localparam t_xlen PC_INCR  = 32'h0000_0004;

  typedef struct packed {
    t_xlen  pc;
    t_instr instr;
  } t_fetch_entry;

  // Force a byte address onto a 4-byte boundary.
  function automatic t_xlen align_word(input t_xlen addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_flush_fifo.sv
// Synchronous FIFO with single-cycle flush.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           empties the FIFO; cancels any push/pop in the same cycle
//   push, wr_data   write request and data
//   pop             read request (head is advanced)
//   rd_data         head entry, zero while empty
//   full, empty     occupancy flags
//   count           number of stored entries
// A push is accepted while full only when a pop happens in the same cycle.
module sync_flush_fifo
  import core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags and the effective push/pop after flush cancellation.
  always_comb begin
    full_s    = (count_r == DEPTH_C);
    empty_s   = (count_r == {CW{1'b0}});
    do_pop_s  = pop && !empty_s && !flush;
    do_push_s = push && (!full_s || do_pop_s) && !flush;
  end

  // Pointer and count state; pointers wrap naturally because DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Head presentation; zero while empty so downstream never sees stale data.
  always_comb begin
    full  = full_s;
    empty = empty_s;
    count = count_r;
    if (empty_s) begin
      rd_data = {WIDTH{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetch stage.
// Issues sequential word fetches from fetch_pc, buffers in-order memory
// responses in a prefetch FIFO and presents {pc, instr} to decode.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr    fetch request channel
//   imem_rsp_valid/data          in-order response channel, never stalled
//   redirect_valid, redirect_pc  branch/jump/trap redirect
//   dec_valid/ready/pc/instr     head of the prefetch FIFO towards decode
// Requests are only issued while outstanding + FIFO occupancy leaves a free
// slot, so every returning response is guaranteed room. On a redirect all
// unreturned responses are counted in drop_cnt and discarded on arrival.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN       = core_pkg::XLEN,
  parameter int              ILEN       = core_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC   = core_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [ILEN-1:0] dec_instr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;

  logic [CW-1:0]   fifo_count_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [CW:0]     credit_used_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            rsp_push_s;
  logic            dec_pop_s;
  logic [XLEN-1:0] redirect_base_s;
  t_fetch_entry    push_entry_s;
  t_fetch_entry    head_entry_s;

  // Credit check, handshakes and the aligned redirect target.
  always_comb begin
    credit_used_s   = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    redirect_base_s = align_word(redirect_pc);
    req_valid_s     = !rst && !redirect_valid && (credit_used_s < DEPTH_C);
    req_fire_s      = req_valid_s && imem_req_ready;
    // Responses are kept only when nothing is marked for discard and no
    // redirect is flushing the FIFO this cycle.
    rsp_push_s      = imem_rsp_valid && (drop_cnt_r == CNT_ZERO) && !redirect_valid
                      && (!fifo_full_s || dec_pop_s);
    dec_pop_s       = !fifo_empty_s && dec_ready;
    push_entry_s.pc    = rsp_pc_r;
    push_entry_s.instr = imem_rsp_data;
  end

  // Request address: redirect target, else advance on each accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_base_s;
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + PC_INCR;
    end
  end

  // PC tag for the next kept response; discarded responses do not advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc_r <= redirect_base_s;
    end else if (rsp_push_s) begin
      rsp_pc_r <= rsp_pc_r + PC_INCR;
    end
  end

  // Requests issued but not yet answered.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= CNT_ZERO;
    end else begin
      case ({req_fire_s, imem_rsp_valid})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Responses still to be discarded. A redirect marks every unreturned
  // request; a response in the redirect cycle is dropped on the spot.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= CNT_ZERO;
    end else if (redirect_valid) begin
      drop_cnt_r <= outstanding_r - (imem_rsp_valid ? CNT_ONE : CNT_ZERO);
    end else if (imem_rsp_valid && (drop_cnt_r != CNT_ZERO)) begin
      drop_cnt_r <= drop_cnt_r - CNT_ONE;
    end
  end

  sync_flush_fifo #(
    .WIDTH ($bits(t_fetch_entry)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .push    (rsp_push_s),
    .wr_data (push_entry_s),
    .pop     (dec_pop_s),
    .rd_data (head_entry_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Output drive.
  always_comb begin
    imem_req_valid = req_valid_s;
    imem_req_addr  = fetch_pc_r;
    dec_valid      = !fifo_empty_s;
    dec_pc         = head_entry_s.pc;
    dec_instr      = head_entry_s.instr;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;
  import core_pkg::*;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN       (32),
    .ILEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr)
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int fire_cnt = 0;
  int pop_cnt = 0;
  int mark;

  logic [31:0]  mq_addr[$];
  int           mq_due[$];
  t_fetch_entry exp_q[$];
  t_fetch_entry mon_e;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Expected decode stream: consecutive words from start (wraps at 32 bits).
  task automatic exp_reset(input logic [31:0] start);
    logic [31:0] pc;
    t_fetch_entry e;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 64; i++) begin
      e.pc    = pc;
      e.instr = instr_of(pc);
      exp_q.push_back(e);
      pc = pc + 32'd4;
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    dec_ready      = rdy;
    lat            = l;
    tick();
    tick();
    exp_reset(32'h0000_0000);
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Memory: a request fired at the coming edge is answered lat cycles later.
  always @(negedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        fire_cnt++;
      end
    end
  end

  // Monitor: every consumed head must match the scoreboard front.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dec_pop: got pc 0x%08h expected no entry", dec_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("dec_pc", dec_pc, mon_e.pc);
        check("dec_instr", dec_instr, mon_e.instr);
      end
      pop_cnt++;
    end
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset state and 1-cycle-latency streaming.
    do_reset(1, 1'b1);
    sample();
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_dec_valid", dec_valid, 32'd0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    sample();
    check("start_dec_valid0", dec_valid, 32'd0);
    tick();
    sample();
    check("start_valid1", dec_valid, 32'd1);
    check("seq_pc0", dec_pc, 32'h0);
    tick();
    sample();
    check("seq_pc4", dec_pc, 32'h4);
    tick();
    sample();
    check("seq_pc8", dec_pc, 32'h8);
    check("seq_instr8", dec_instr, instr_of(32'h8));

    // Stall: credits run out after FIFO_DEPTH requests.
    tick();
    do_reset(1, 1'b0);
    rst  = 1'b0;
    mark = fire_cnt;
    for (int i = 0; i < 10; i++) tick();
    sample();
    check("stall_fires", fire_cnt - mark, 32'd4);
    check("stall_req_valid", imem_req_valid, 32'd0);
    check("stall_head_valid", dec_valid, 32'd1);
    check("stall_head_pc", dec_pc, 32'h0);
    tick();
    dec_ready = 1'b1;
    mark = pop_cnt;
    tick();
    sample();
    check("resume_addr", imem_req_addr, 32'h10);
    check("resume_valid", imem_req_valid, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("resume_pops", (pop_cnt - mark >= 5) ? 32'd1 : 32'd0, 32'd1);

    // 3-cycle latency: redirect with 0x0/0x4/0x8 in flight and rsp(0x0) arriving.
    do_reset(3, 1'b1);
    rst = 1'b0;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    exp_reset(32'h0000_0100);
    sample();
    check("rdC_rsp_coincident", imem_rsp_valid, 32'd1);
    check("rdC_req_blocked", imem_req_valid, 32'd0);
    tick();
    redirect_valid = 1'b0;
    sample();
    check("rdC_dec_valid", dec_valid, 32'd0);
    check("rdC_addr", imem_req_addr, 32'h100);
    mark = pop_cnt;
    for (int i = 0; i < 14; i++) tick();
    check("rdC_pops", (pop_cnt - mark >= 3) ? 32'd1 : 32'd0, 32'd1);

    // Redirect coincident with a response and a decode pop; unaligned target.
    do_reset(3, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    exp_reset(32'h0000_0200);
    sample();
    check("rdD_head_valid", dec_valid, 32'd1);
    check("rdD_rsp_coincident", imem_rsp_valid, 32'd1);
    tick();
    redirect_valid = 1'b0;
    sample();
    check("rdD_flushed", dec_valid, 32'd0);
    check("rdD_aligned_addr", imem_req_addr, 32'h200);
    check("rdD_req_valid", imem_req_valid, 32'd1);
    mark = pop_cnt;
    for (int i = 0; i < 14; i++) tick();
    check("rdD_pops", (pop_cnt - mark >= 3) ? 32'd1 : 32'd0, 32'd1);

    // Wrap-around redirect while streaming.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    exp_reset(32'hFFFF_FFF8);
    sample();
    check("wrap_req_blocked", imem_req_valid, 32'd0);
    tick();
    redirect_valid = 1'b0;
    sample();
    check("wrap_addr", imem_req_addr, 32'hFFFF_FFF8);
    mark = pop_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("wrap_pops", (pop_cnt - mark >= 3) ? 32'd1 : 32'd0, 32'd1);

    // Reset mid-stream with 2 outstanding and the FIFO half full.
    do_reset(3, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    sample();
    check("mid_head_pc", dec_pc, 32'h0);
    check("mid_req_valid", imem_req_valid, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    sample();
    check("midrst_addr", imem_req_addr, 32'h0);
    check("midrst_dec_valid", dec_valid, 32'd0);
    check("midrst_dec_pc", dec_pc, 32'h0);
    check("midrst_req_valid", imem_req_valid, 32'd0);
    tick();
    exp_reset(32'h0000_0000);
    rst  = 1'b0;
    mark = fire_cnt;
    for (int i = 0; i < 12; i++) tick();
    check("postrst_fires", fire_cnt - mark, 32'd4);
    dec_ready = 1'b1;
    mark = pop_cnt;
    for (int i = 0; i < 12; i++) tick();
    check("postrst_pops", (pop_cnt - mark >= 4) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
